data_packer: RTL and testbench
==============================

DATA_PACKER -- requirements
Module: data_packer

Interface
REQ-001 SHALL have parameter N, default 8, meaning vector lanes per input and output.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bits per lane.
REQ-003 SHALL have parameter MAX_CHAINS, default 4, meaning independent packing contexts; power of two, >=2; CW=$clog2(MAX_CHAINS).
REQ-004 SHALL have parameter PERSONAL_CONFIG_ID, default 0, meaning configId value addressing this block.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-007 SHALL have port valid_in, input, 1 bit, meaning vector_in is valid this cycle.
REQ-008 SHALL have port eof_in, input, 1 bit, meaning end of frame for chainId_in; may be asserted with or without valid_in.
REQ-009 SHALL have port chainId_in, input, CW bits, meaning chain selecting the context for data, eof and config.
REQ-010 SHALL have port tracing, input, 1 bit, meaning 1 = process data, 0 = configuration window.
REQ-011 SHALL have port configId, input, 8 bits, meaning target block ID of configData.
REQ-012 SHALL have port configData, input, 8 bits, meaning configuration byte; bits [1:0] = mode.
REQ-013 SHALL have port vector_in, input, N x DATA_WIDTH, meaning the upstream reduce-stage output vector.
REQ-014 SHALL have port valid_out, output, 1 bit, meaning vector_out is valid.
REQ-015 SHALL have port chainId_out, output, CW bits, meaning chain of the emitted vector.
REQ-016 SHALL have port vector_out, output, N x DATA_WIDTH, meaning the packed or passed-through vector.

Function
REQ-017 SHALL hold a 2-bit mode per chain; mode 0 = pass-through, mode 1 = pack scalar; modes 2 and 3 SHALL behave as mode 0.
REQ-018 SHALL write mode[chainId_in] <= configData[1:0] when tracing==0 and configId==PERSONAL_CONFIG_ID; the same edge SHALL clear count and buffer of that chain (partial data discarded, no output).
REQ-019 SHALL ignore valid_in and eof_in when tracing==0; valid_out SHALL be 0 on the following cycle.
REQ-020 SHALL keep per chain a buffer of N lanes and a counter count in 0..N-1.
REQ-021 In mode 0, valid_in SHALL produce valid_out=1, vector_out=vector_in, chainId_out=chainId_in on the next edge (latency 1); eof_in SHALL have no further effect.
REQ-022 In mode 1, valid_in SHALL write vector_in[0] into buffer lane count and increment count; other lanes of vector_in SHALL be ignored.
REQ-023 In mode 1, when the written lane is N-1, the full buffer SHALL be emitted next cycle (valid_out=1), and count and buffer SHALL clear to 0.
REQ-024 In mode 1, valid_in with eof_in SHALL include the element and then emit, with unwritten lanes zero, even if count was 0 beforehand.
REQ-025 In mode 1, eof_in without valid_in SHALL emit the zero-padded buffer if count>0 and emit nothing if count==0; the chain then clears.
REQ-026 SHALL never emit more than one vector per cycle; only the chainId_in context changes per cycle, so other chains' partial buffers SHALL persist unchanged.
REQ-027 When no emission occurs, valid_out SHALL be 0 and vector_out and chainId_out SHALL hold their last values.
REQ-028 SHALL not apply back-pressure; downstream SHALL accept every valid_out.

Reset
REQ-029 SHALL, while reset==1, force valid_out=0, vector_out all lanes 0, chainId_out=0, all counts 0, all buffers 0, and all modes 0, independent of clk.
REQ-030 Reset asserted mid-frame SHALL discard all partial data without emitting; the first edge after deassertion SHALL process inputs normally.

Verification
REQ-031 Pass-through: mode 0, tracing=1, chain 2, valid_in with lanes 1..8 -> next cycle valid_out=1, vector_out=1..8, chainId_out=2.
REQ-032 Full pack: chain 0 mode 1, 8 valid inputs with lane0 = 10,20,...,80 -> single valid_out after 8th input, vector_out=10..80, and no earlier valid_out.
REQ-033 EOF flush: chain 1 mode 1, 3 inputs 5,6,7 then eof_in alone -> vector_out=5,6,7,0,0,0,0,0; a following eof_in alone -> no valid_out.
REQ-034 Interleave: chain 0 gets 2 elements, chain 3 gets 8 elements, chain 0 gets 6 more -> two outputs, chain 3 first, each containing only its own chain's values in order.
REQ-035 Reset and config: 4 elements in chain 0, reset pulse, then eof_in -> no valid_out and mode reads back 0 (pass-through); a config write with tracing=1 -> ignored.

Source files
------------

// File: rtl/data_packer.sv
`default_nettype none
// ============================================================================
// Module      : data_packer
// Description : Per-chain scalar packer sitting behind a vector reduce stage.
//               Each of MAX_CHAINS contexts has a 2-bit mode:
//                 mode 1      : lane 0 of every valid input vector is appended
//                               to the chain's N-lane buffer; the buffer is
//                               emitted when full or on end of frame, with
//                               unwritten lanes zero.
//                 mode 0/2/3  : input vectors pass straight through with one
//                               cycle of latency.
//               While tracing is low, inputs are a configuration window: a
//               byte addressed to PERSONAL_CONFIG_ID sets the selected chain's
//               mode and discards its partial buffer.
// Ports       : clk         - clock, all state on rising edge
//               reset       - asynchronous active-high reset
//               valid_in    - vector_in valid
//               eof_in      - end of frame for chainId_in
//               chainId_in  - context selector for data, eof and config
//               tracing     - 1 = data processing, 0 = configuration window
//               configId    - target block ID of configData
//               configData  - configuration byte, [1:0] = mode
//               vector_in   - N lanes of DATA_WIDTH bits, lane i at [i*DW +: DW]
//               valid_out   - vector_out valid (no back-pressure)
//               chainId_out - chain of the emitted vector
//               vector_out  - packed or passed-through vector
// Revision    : 1.0 - initial release
// ============================================================================
module data_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic                          tracing,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic                          valid_out,
  output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
  output logic [N*DATA_WIDTH-1:0]       vector_out
);

  localparam int c_CW   = $clog2(MAX_CHAINS);
  localparam int c_CNTW = (N > 1) ? $clog2(N) : 1;
  localparam int c_VW   = N * DATA_WIDTH;

  localparam logic [c_CNTW-1:0] c_LAST_LANE = c_CNTW'(N - 1);
  localparam logic [1:0]        c_MODE_PACK = 2'd1;

  // Per-chain context
  logic [1:0]        r_mode  [MAX_CHAINS];
  logic [c_CNTW-1:0] r_count [MAX_CHAINS];
  logic [c_VW-1:0]   r_buf   [MAX_CHAINS];

  logic [c_CNTW-1:0] w_cur_count;
  logic [c_VW-1:0]   w_cur_buf;
  logic [c_VW-1:0]   w_merged;
  logic              w_cfg_hit;
  logic              w_pack;
  logic              w_full;
  logic              w_pack_emit;
  logic              w_pack_clear;
  logic              w_pass_emit;
  logic              w_emit;
  logic [c_VW-1:0]   w_emit_vec;
  logic              w_unused_cfg;

  assign w_cur_count = r_count[chainId_in];
  assign w_cur_buf   = r_buf[chainId_in];

  // Only the mode field of the configuration byte is meaningful here.
  assign w_unused_cfg = ^configData[7:2];

  assign w_cfg_hit = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
  assign w_pack    = tracing && (r_mode[chainId_in] == c_MODE_PACK);
  assign w_full    = valid_in && (w_cur_count == c_LAST_LANE);

  // Buffer contents as they stand once this cycle's scalar is written in.
  // Emission on a full or eof'd buffer uses this view so the final element
  // goes out in the same vector without an extra cycle.
  always_comb begin
    w_merged = w_cur_buf;
    if (valid_in) begin
      w_merged[int'(w_cur_count)*DATA_WIDTH +: DATA_WIDTH] = vector_in[DATA_WIDTH-1:0];
    end
  end

  // A bare eof on an empty chain produces nothing; valid+eof always emits,
  // because the new element makes the buffer non-empty.
  assign w_pack_emit  = w_pack && (w_full || (eof_in && (valid_in || (w_cur_count != '0))));
  assign w_pack_clear = w_pack && (w_full || eof_in);
  assign w_pass_emit  = tracing && !w_pack && valid_in;
  assign w_emit       = w_pack_emit || w_pass_emit;
  assign w_emit_vec   = w_pack ? w_merged : vector_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out   <= 1'b0;
      chainId_out <= '0;
      vector_out  <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) begin
        r_mode[i]  <= '0;
        r_count[i] <= '0;
        r_buf[i]   <= '0;
      end
    end else begin
      valid_out <= w_emit;
      // Outputs hold their last payload when nothing is emitted.
      if (w_emit) begin
        vector_out  <= w_emit_vec;
        chainId_out <= c_CW'(chainId_in);
      end

      // Only the selected chain's context changes in any cycle.
      if (w_cfg_hit) begin
        r_mode[chainId_in]  <= configData[1:0];
        r_count[chainId_in] <= '0;
        r_buf[chainId_in]   <= '0;
      end else if (w_pack_clear) begin
        r_count[chainId_in] <= '0;
        r_buf[chainId_in]   <= '0;
      end else if (w_pack && valid_in) begin
        r_count[chainId_in] <= w_cur_count + 1'b1;
        r_buf[chainId_in]   <= w_merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_packer
// Description : Self-checking bench for data_packer. Directed scenarios plus
//               a randomized run compared against a queue-based model of the
//               per-chain packing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_packer;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int MC  = 4;
  localparam int CW  = 2;
  localparam int PID = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            eof_in;
  logic [CW-1:0]   chainId_in;
  logic            tracing;
  logic [7:0]      configId;
  logic [7:0]      configData;
  logic [N*DW-1:0] vector_in;
  logic            valid_out;
  logic [CW-1:0]   chainId_out;
  logic [N*DW-1:0] vector_out;

  int errors = 0;
  int checks = 0;

  // Reference model: mode per chain, collected scalars per chain as a queue,
  // and the expected output registers.
  logic [1:0]      m_mode [MC];
  logic [DW-1:0]   m_q    [MC][$];
  logic            exp_valid;
  logic [CW-1:0]   exp_ch;
  logic [N*DW-1:0] exp_vec;

  data_packer #(
    .N                 (N),
    .DATA_WIDTH        (DW),
    .MAX_CHAINS        (MC),
    .PERSONAL_CONFIG_ID(PID)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .chainId_in (chainId_in),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .vector_in  (vector_in),
    .valid_out  (valid_out),
    .chainId_out(chainId_out),
    .vector_out (vector_out)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < MC; c++) begin
      m_mode[c] = 2'd0;
      m_q[c].delete();
    end
    exp_valid = 1'b0;
    exp_ch    = '0;
    exp_vec   = '0;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // Vector whose lanes are base, base+step, ... for the first cnt lanes, zero after.
  function automatic logic [N*DW-1:0] seq_vec(input int base, input int step, input int cnt);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < cnt; i++) v[i*DW +: DW] = DW'(base + i*step);
    return v;
  endfunction

  // Applies one cycle of inputs (called just after a rising edge), advances
  // the model, and returns 1 ns after the next rising edge with idle inputs.
  task automatic drive(input bit v, input bit e, input int ch, input bit tr,
                       input logic [7:0] cid, input logic [7:0] cdat,
                       input logic [N*DW-1:0] vec);
    valid_in   = v;
    eof_in     = e;
    chainId_in = CW'(ch);
    tracing    = tr;
    configId   = cid;
    configData = cdat;
    vector_in  = vec;

    exp_valid = 1'b0;
    if (!tr) begin
      if (cid == 8'(PID)) begin
        m_mode[ch] = cdat[1:0];
        m_q[ch].delete();
      end
    end else if (m_mode[ch] == 2'd1) begin
      if (v) m_q[ch].push_back(vec[DW-1:0]);
      if ((m_q[ch].size() == N) || (e && m_q[ch].size() > 0)) begin
        exp_valid = 1'b1;
        exp_ch    = CW'(ch);
        exp_vec   = '0;
        for (int i = 0; i < m_q[ch].size(); i++) exp_vec[i*DW +: DW] = m_q[ch][i];
      end
      if (e || m_q[ch].size() == N) m_q[ch].delete();
    end else if (v) begin
      exp_valid = 1'b1;
      exp_ch    = CW'(ch);
      exp_vec   = vec;
    end

    @(posedge clk);
    #1;
    valid_in = 1'b0;
    eof_in   = 1'b0;
    tracing  = 1'b1;
  endtask

  task automatic push(input int ch, input int val, input bit e = 1'b0);
    logic [N*DW-1:0] v;
    v = rand_vec();
    v[DW-1:0] = DW'(val);
    drive(1'b1, e, ch, 1'b1, 8'(PID), 8'h01, v);
  endtask

  task automatic eof_only(input int ch);
    drive(1'b0, 1'b1, ch, 1'b1, 8'(PID), 8'h01, rand_vec());
  endtask

  // Config write with data/eof also asserted, which must be ignored.
  task automatic cfg(input int ch, input logic [1:0] mode);
    logic [7:0] d;
    d = 8'($urandom);
    d[1:0] = mode;
    drive(1'b1, 1'b1, ch, 1'b0, 8'(PID), d, rand_vec());
  endtask

  task automatic test_reset();
    #2;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (vector_out !== '0) begin errors++; $display("FAIL reset_vector: got %h expected 0", vector_out); end
    checks++; if (chainId_out !== '0) begin errors++; $display("FAIL reset_chain: got %0d expected 0", chainId_out); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [N*DW-1:0] ev;
    ev = seq_vec(1, 1, 8);
    drive(1'b1, 1'b0, 2, 1'b1, 8'h00, 8'h00, ev);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b expected 1", valid_out); end
    checks++; if (vector_out !== ev) begin errors++; $display("FAIL pass_vector: got %h expected %h", vector_out, ev); end
    checks++; if (chainId_out !== 2'd2) begin errors++; $display("FAIL pass_chain: got %0d expected 2", chainId_out); end
    // eof in pass-through mode has no further effect; outputs hold.
    eof_only(2);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL pass_idle_valid: got %b expected 0", valid_out); end
    checks++; if (vector_out !== ev || chainId_out !== 2'd2) begin errors++; $display("FAIL pass_hold: got %h/%0d expected %h/2", vector_out, chainId_out, ev); end
  endtask

  task automatic test_tracing_gate();
    logic [N*DW-1:0] held;
    held = vector_out;
    // Config window with a foreign configId: data ignored, mode untouched.
    drive(1'b1, 1'b1, 2, 1'b0, 8'(PID + 1), 8'h01, rand_vec());
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL gate_valid: got %b expected 0", valid_out); end
    checks++; if (vector_out !== held) begin errors++; $display("FAIL gate_hold: got %h expected %h", vector_out, held); end
    push(2, 77);
    checks++; if (valid_out !== 1'b1 || vector_out !== exp_vec) begin errors++; $display("FAIL gate_mode_kept: got %b/%h expected 1/%h", valid_out, vector_out, exp_vec); end
  endtask

  task automatic test_full_pack();
    logic [N*DW-1:0] ev;
    cfg(0, 2'd1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cfg_valid: got %b expected 0", valid_out); end
    for (int i = 0; i < N; i++) begin
      push(0, (i + 1) * 10);
      checks++;
      if (valid_out !== (i == N - 1)) begin errors++; $display("FAIL full_valid[%0d]: got %b expected %b", i, valid_out, (i == N - 1)); end
    end
    ev = seq_vec(10, 10, 8);
    checks++; if (vector_out !== ev) begin errors++; $display("FAIL full_vector: got %h expected %h", vector_out, ev); end
    checks++; if (chainId_out !== 2'd0) begin errors++; $display("FAIL full_chain: got %0d expected 0", chainId_out); end
  endtask

  task automatic test_eof_flush();
    logic [N*DW-1:0] ev;
    cfg(1, 2'd1);
    push(1, 5); push(1, 6); push(1, 7);
    eof_only(1);
    ev = seq_vec(5, 1, 3);
    checks++; if (valid_out !== 1'b1 || vector_out !== ev || chainId_out !== 2'd1) begin errors++; $display("FAIL eof_flush: got %b/%h/%0d expected 1/%h/1", valid_out, vector_out, chainId_out, ev); end
    eof_only(1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL eof_empty: got %b expected 0", valid_out); end
    // valid with eof on an empty chain emits a single-element vector.
    push(1, 9, 1'b1);
    ev = seq_vec(9, 0, 1);
    checks++; if (valid_out !== 1'b1 || vector_out !== ev) begin errors++; $display("FAIL eof_single: got %b/%h expected 1/%h", valid_out, vector_out, ev); end
    // Re-config mid-frame discards the partial buffer silently.
    push(1, 1); push(1, 2);
    cfg(1, 2'd1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cfg_discard_valid: got %b expected 0", valid_out); end
    eof_only(1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cfg_discard_eof: got %b expected 0", valid_out); end
  endtask

  task automatic test_interleave();
    logic [N*DW-1:0] ev;
    int nout;
    nout = 0;
    cfg(3, 2'd1);
    for (int i = 0; i < 2; i++) begin push(0, 100 + i); if (valid_out === 1'b1) nout++; end
    for (int i = 0; i < 8; i++) begin push(3, 200 + i); if (valid_out === 1'b1) nout++; end
    ev = seq_vec(200, 1, 8);
    checks++; if (valid_out !== 1'b1 || chainId_out !== 2'd3 || vector_out !== ev) begin errors++; $display("FAIL inter_chain3: got %b/%0d/%h expected 1/3/%h", valid_out, chainId_out, vector_out, ev); end
    for (int i = 2; i < 8; i++) begin push(0, 100 + i); if (valid_out === 1'b1) nout++; end
    ev = seq_vec(100, 1, 8);
    checks++; if (valid_out !== 1'b1 || chainId_out !== 2'd0 || vector_out !== ev) begin errors++; $display("FAIL inter_chain0: got %b/%0d/%h expected 1/0/%h", valid_out, chainId_out, vector_out, ev); end
    checks++; if (nout != 2) begin errors++; $display("FAIL inter_count: got %0d expected 2", nout); end
  endtask

  task automatic test_reset_config();
    logic [N*DW-1:0] v;
    for (int i = 0; i < 4; i++) push(0, 40 + i);
    // Asynchronous pulse between edges; outputs must clear without a clock.
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (valid_out !== 1'b0 || vector_out !== '0 || chainId_out !== '0) begin errors++; $display("FAIL midreset_outputs: got %b/%h/%0d expected 0/0/0", valid_out, vector_out, chainId_out); end
    reset = 1'b0;
    eof_only(0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midreset_eof: got %b expected 0", valid_out); end
    v = rand_vec();
    drive(1'b1, 1'b0, 0, 1'b1, 8'h00, 8'h00, v);
    checks++; if (valid_out !== 1'b1 || vector_out !== v) begin errors++; $display("FAIL midreset_mode0: got %b/%h expected 1/%h", valid_out, vector_out, v); end
    // Config byte addressed to this block while tracing is ignored.
    v = rand_vec();
    drive(1'b1, 1'b0, 0, 1'b1, 8'(PID), 8'h01, v);
    v = rand_vec();
    drive(1'b1, 1'b0, 0, 1'b1, 8'h00, 8'h00, v);
    checks++; if (valid_out !== 1'b1 || vector_out !== v) begin errors++; $display("FAIL trace_cfg_ignored: got %b/%h expected 1/%h", valid_out, vector_out, v); end
  endtask

  task automatic test_random();
    bit v, e, tr;
    int ch;
    logic [7:0] cid;
    for (int k = 0; k < 400; k++) begin
      tr  = ($urandom % 8) != 0;
      v   = ($urandom % 4) != 0;
      e   = ($urandom % 5) == 0;
      ch  = int'($urandom % MC);
      cid = ($urandom % 2) ? 8'(PID) : 8'($urandom);
      drive(v, e, ch, tr, cid, 8'($urandom), rand_vec());
      checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", k, valid_out, exp_valid); end
      checks++; if (chainId_out !== exp_ch) begin errors++; $display("FAIL rand_chain[%0d]: got %0d expected %0d", k, chainId_out, exp_ch); end
      checks++; if (vector_out !== exp_vec) begin errors++; $display("FAIL rand_vector[%0d]: got %h expected %h", k, vector_out, exp_vec); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    valid_in   = 1'b0;
    eof_in     = 1'b0;
    chainId_in = '0;
    tracing    = 1'b1;
    configId   = 8'h00;
    configData = 8'h00;
    vector_in  = '0;
    model_reset();
    #7;
    test_reset();
    test_passthrough();
    test_tracing_gate();
    test_full_pack();
    test_eof_flush();
    test_interleave();
    test_reset_config();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
